// File: rtl/sdram_cmd_arbiter.sv
// SDRAM command/address bus arbiter for the init, auto-refresh, write and read engines.
// Define SDRAM_ARB_RR_EN for write/read round-robin; the default build gives write fixed priority over read.
module sdram_cmd_arbiter #(
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        init_done,
    input  logic [3:0]  init_cmds,
    input  logic [10:0] init_addr,
    input  logic [1:0]  init_ba,

    input  logic        aref_req,
    input  logic        aref_done,
    output logic        aref_en,
    input  logic [3:0]  aref_cmds,
    input  logic [10:0] aref_addr,
    input  logic [1:0]  aref_ba,

    input  logic        wr_req,
    input  logic        wr_done,
    output logic        wr_en,
    input  logic [3:0]  wr_cmds,
    input  logic [10:0] wr_addr,
    input  logic [1:0]  wr_ba,

    input  logic        rd_req,
    input  logic        rd_done,
    output logic        rd_en,
    input  logic [3:0]  rd_cmds,
    input  logic [10:0] rd_addr,
    input  logic [1:0]  rd_ba,

    output logic [3:0]  sdr_cmds,
    output logic [10:0] sdr_addr,
    output logic [1:0]  sdr_ba,
    output logic [2:0]  arb_state,
    output logic        arb_timeout
);

    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_AREF  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_READ  = 3'd4;

    localparam logic [3:0]  CMD_NOP  = 4'b0111;
    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT);

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic        aref_pend;
    logic [15:0] wd_cnt;
    logic        wd_fire;
    logic        sel_wr;
    logic        sel_rd;

    logic [3:0]  bus_cmds;
    logic [10:0] bus_addr;
    logic [1:0]  bus_ba;

`ifdef SDRAM_ARB_RR_EN
    // last_wr remembers which data engine was served last so a contended pair alternates.
    logic last_wr;

    always_comb begin
        sel_wr = wr_req && (!rd_req || !last_wr);
        sel_rd = rd_req && (!wr_req || last_wr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_wr <= 1'b0;
        end else if (state == S_IDLE && state_nxt == S_WRITE) begin
            last_wr <= 1'b1;
        end else if (state == S_IDLE && state_nxt == S_READ) begin
            last_wr <= 1'b0;
        end
    end
`else
    always_comb begin
        sel_wr = wr_req;
        sel_rd = rd_req && !wr_req;
    end
`endif

    // Busy states only ever return to IDLE, which guarantees a gap cycle between grants.
    always_comb begin
        state_nxt = state;
        wd_fire   = 1'b0;
        case (state)
            S_INIT: begin
                if (init_done) state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (aref_pend)   state_nxt = S_AREF;
                else if (sel_wr) state_nxt = S_WRITE;
                else if (sel_rd) state_nxt = S_READ;
            end
            S_AREF: begin
                if (aref_done) begin
                    state_nxt = S_IDLE;
                end else if (wd_cnt == WD_LIMIT) begin
                    state_nxt = S_IDLE;
                    wd_fire   = 1'b1;
                end
            end
            S_WRITE: begin
                if (wr_done) begin
                    state_nxt = S_IDLE;
                end else if (wd_cnt == WD_LIMIT) begin
                    state_nxt = S_IDLE;
                    wd_fire   = 1'b1;
                end
            end
            S_READ: begin
                if (rd_done) begin
                    state_nxt = S_IDLE;
                end else if (wd_cnt == WD_LIMIT) begin
                    state_nxt = S_IDLE;
                    wd_fire   = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // The pins follow the current owner, so engine timing reaches the SDRAM delayed by exactly one cycle.
    always_comb begin
        bus_cmds = CMD_NOP;
        bus_addr = '0;
        bus_ba   = '0;
        case (state)
            S_INIT: begin
                bus_cmds = init_cmds;
                bus_addr = init_addr;
                bus_ba   = init_ba;
            end
            S_AREF: begin
                bus_cmds = aref_cmds;
                bus_addr = aref_addr;
                bus_ba   = aref_ba;
            end
            S_WRITE: begin
                bus_cmds = wr_cmds;
                bus_addr = wr_addr;
                bus_ba   = wr_ba;
            end
            S_READ: begin
                bus_cmds = rd_cmds;
                bus_addr = rd_addr;
                bus_ba   = rd_ba;
            end
            default: begin
                bus_cmds = CMD_NOP;
                bus_addr = '0;
                bus_ba   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_INIT;
            aref_pend   <= 1'b0;
            wd_cnt      <= '0;
            aref_en     <= 1'b0;
            wr_en       <= 1'b0;
            rd_en       <= 1'b0;
            arb_timeout <= 1'b0;
            sdr_cmds    <= CMD_NOP;
            sdr_addr    <= '0;
            sdr_ba      <= '0;
        end else begin
            state       <= state_nxt;
            // A new request in the same cycle as the grant wins over the clear.
            aref_pend   <= (aref_req && state != S_INIT) ||
                           (aref_pend && !(state == S_IDLE && state_nxt == S_AREF));
            if (state_nxt != state || state == S_IDLE || state == S_INIT) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + 16'd1;
            end
            aref_en     <= (state_nxt == S_AREF);
            wr_en       <= (state_nxt == S_WRITE);
            rd_en       <= (state_nxt == S_READ);
            arb_timeout <= wd_fire;
            sdr_cmds    <= bus_cmds;
            sdr_addr    <= bus_addr;
            sdr_ba      <= bus_ba;
        end
    end

    assign arb_state = state;

endmodule
